// File: rtl/parse_pkt_disp_nch_if.sv
// Bus bundle for parse_pkt_disp_nch: upstream packet/metadata stream, buf_addr_full
// throttle, per-channel usedw and the one-hot dispatched output streams.
interface parse_pkt_disp_nch_if #(
  parameter int NCH = 4
);
  logic                 pkt_valid;
  logic [138:0]         pkt_data;
  logic                 pkt_metadata_valid;
  logic [359:0]         pkt_metadata;
  logic                 buf_addr_full;
  logic [8*NCH-1:0]     ch_usedw;
  logic [NCH-1:0]       out_data_valid;
  logic [138:0]         out_data;
  logic [NCH-1:0]       out_meta_valid;
  logic [359:0]         out_meta;

  modport master (
    output pkt_valid, pkt_data, pkt_metadata_valid, pkt_metadata, ch_usedw,
    input  buf_addr_full, out_data_valid, out_data, out_meta_valid, out_meta
  );

  modport slave (
    input  pkt_valid, pkt_data, pkt_metadata_valid, pkt_metadata, ch_usedw,
    output buf_addr_full, out_data_valid, out_data, out_meta_valid, out_meta
  );
endinterface

// File: rtl/parse_pkt_disp_nch.sv
// N-channel packet dispatcher: buffers words and metadata, routes each packet by its action byte.
// Optional DISP_DROP_ON_FULL_EN: a busy target channel drops the packet instead of waiting.
module parse_pkt_disp_nch #(
  parameter int NCH         = 4,
  parameter int CH_W        = 2,
  parameter int DATA_DEPTH  = 256,
  parameter int META_DEPTH  = 16,
  parameter int FULL_MARGIN = 64,
  parameter int USEDW_TH    = 200
) (
  input  logic                 clk,
  input  logic                 reset,
  parse_pkt_disp_nch_if.slave  bus,
  output logic [31:0]          drop_cnt
);

  localparam int DAW = $clog2(DATA_DEPTH);
  localparam int MAW = $clog2(META_DEPTH);
  localparam logic [DAW:0]     DATA_DEPTH_C = (DAW+1)'(DATA_DEPTH);
  localparam logic [DAW:0]     MARGIN_C     = (DAW+1)'(FULL_MARGIN);
  localparam logic [DAW:0]     D_ONE_C      = (DAW+1)'(1);
  localparam logic [DAW-1:0]   D_PTR_ONE_C  = DAW'(1);
  localparam logic [MAW:0]     META_DEPTH_C = (MAW+1)'(META_DEPTH);
  localparam logic [MAW:0]     META_LIM_C   = (MAW+1)'(META_DEPTH - 1);
  localparam logic [MAW:0]     M_ONE_C      = (MAW+1)'(1);
  localparam logic [MAW-1:0]   M_PTR_ONE_C  = MAW'(1);
  localparam logic [6:0]       NCH_C        = 7'(NCH);
  localparam logic [7:0]       USEDW_TH_C   = 8'(USEDW_TH);
  localparam logic [NCH-1:0]   ONEHOT_C     = NCH'(1);
  localparam logic [2:0]       CODE_TAIL    = 3'b110;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DECIDE = 3'd1,
    ST_WAIT   = 3'd2,
    ST_SEND   = 3'd3,
    ST_DROP   = 3'd4
  } state_e;

  logic [138:0]    data_mem_q [DATA_DEPTH];
  logic [359:0]    meta_mem_q [META_DEPTH];
  logic [DAW-1:0]  data_wr_ptr_q, data_rd_ptr_q;
  logic [DAW:0]    data_cnt_q, data_cnt_d;
  logic [MAW-1:0]  meta_wr_ptr_q, meta_rd_ptr_q;
  logic [MAW:0]    meta_cnt_q, meta_cnt_d;

  state_e          state_q, state_d;
  logic [CH_W-1:0] ch_q, ch_d;
  logic            first_q, first_d;
  logic [NCH-1:0]  out_data_valid_q, out_data_valid_d;
  logic [138:0]    out_data_q, out_data_d;
  logic [NCH-1:0]  out_meta_valid_q, out_meta_valid_d;
  logic [359:0]    out_meta_q, out_meta_d;
  logic [31:0]     drop_cnt_q, drop_cnt_d;
  logic            buf_full_q, buf_full_d;

  logic            data_wr_s, data_rd_s, meta_wr_s, meta_rd_s;
  logic            data_empty_s, meta_empty_s, drop_act_s, is_tail_s;
  logic [138:0]    data_head_s;
  logic [359:0]    meta_head_s;
  logic [NCH-1:0]  oh_s;

  function automatic logic ch_busy(input logic [8*NCH-1:0] usedw, input logic [CH_W-1:0] ch);
    logic busy;
    busy = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      if (ch == CH_W'(k)) begin
        busy = (usedw[8*k +: 8] > USEDW_TH_C);
      end else begin
        busy = busy;
      end
    end
    return busy;
  endfunction

  // FIFO status, head words and write/read accounting
  always_comb begin
    data_empty_s = (data_cnt_q == {(DAW+1){1'b0}});
    meta_empty_s = (meta_cnt_q == {(MAW+1){1'b0}});
    data_wr_s    = bus.pkt_valid && (data_cnt_q != DATA_DEPTH_C);
    meta_wr_s    = bus.pkt_metadata_valid && (meta_cnt_q != META_DEPTH_C);
    data_head_s  = data_mem_q[data_rd_ptr_q];
    meta_head_s  = meta_mem_q[meta_rd_ptr_q];
    is_tail_s    = (data_head_s[138:136] == CODE_TAIL);
    drop_act_s   = meta_head_s[359] | (meta_head_s[358:352] >= NCH_C);
    oh_s         = ONEHOT_C << ch_q;
    case ({data_wr_s, data_rd_s})
      2'b10:   data_cnt_d = data_cnt_q + D_ONE_C;
      2'b01:   data_cnt_d = data_cnt_q - D_ONE_C;
      default: data_cnt_d = data_cnt_q;
    endcase
    case ({meta_wr_s, meta_rd_s})
      2'b10:   meta_cnt_d = meta_cnt_q + M_ONE_C;
      2'b01:   meta_cnt_d = meta_cnt_q - M_ONE_C;
      default: meta_cnt_d = meta_cnt_q;
    endcase
    buf_full_d = ((DATA_DEPTH_C - data_cnt_q) < MARGIN_C) || (meta_cnt_q >= META_LIM_C);
  end

  // Dispatch FSM: next state, FIFO pops and registered output values
  always_comb begin
    state_d          = state_q;
    ch_d             = ch_q;
    first_d          = first_q;
    data_rd_s        = 1'b0;
    meta_rd_s        = 1'b0;
    out_data_valid_d = {NCH{1'b0}};
    out_data_d       = out_data_q;
    out_meta_valid_d = {NCH{1'b0}};
    out_meta_d       = out_meta_q;
    drop_cnt_d       = drop_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (!meta_empty_s) state_d = ST_DECIDE;
        else               state_d = ST_IDLE;
      end
      ST_DECIDE: begin
        ch_d    = meta_head_s[352 +: CH_W];
        first_d = 1'b1;
        if (drop_act_s) begin
          state_d = ST_DROP;
        end else if (ch_busy(bus.ch_usedw, meta_head_s[352 +: CH_W])) begin
`ifdef DISP_DROP_ON_FULL_EN
          state_d = ST_DROP;
`else
          state_d = ST_WAIT;
`endif
        end else begin
          state_d = ST_SEND;
        end
      end
      ST_WAIT: begin
        if (!ch_busy(bus.ch_usedw, ch_q)) state_d = ST_SEND;
        else                              state_d = ST_WAIT;
      end
      ST_SEND: begin
        if (!data_empty_s) begin
          data_rd_s        = 1'b1;
          out_data_d       = data_head_s;
          out_data_valid_d = oh_s;
          // Metadata leaves with the first word of the packet only
          if (first_q) begin
            meta_rd_s        = 1'b1;
            out_meta_valid_d = oh_s;
            out_meta_d       = meta_head_s;
            first_d          = 1'b0;
          end else begin
            first_d = 1'b0;
          end
          if (is_tail_s) state_d = ST_IDLE;
          else           state_d = ST_SEND;
        end else begin
          state_d = ST_SEND;
        end
      end
      ST_DROP: begin
        if (!data_empty_s) begin
          data_rd_s = 1'b1;
          if (is_tail_s) begin
            meta_rd_s  = 1'b1;
            drop_cnt_d = drop_cnt_q + 32'd1;
            state_d    = ST_IDLE;
          end else begin
            state_d = ST_DROP;
          end
        end else begin
          state_d = ST_DROP;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Buffer storage; contents need no reset because pointers define validity
  always_ff @(posedge clk) begin
    if (data_wr_s) data_mem_q[data_wr_ptr_q] <= bus.pkt_data;
    if (meta_wr_s) meta_mem_q[meta_wr_ptr_q] <= bus.pkt_metadata;
  end

  // State, pointers, counters and output registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q          <= ST_IDLE;
      ch_q             <= {CH_W{1'b0}};
      first_q          <= 1'b0;
      data_wr_ptr_q    <= {DAW{1'b0}};
      data_rd_ptr_q    <= {DAW{1'b0}};
      data_cnt_q       <= {(DAW+1){1'b0}};
      meta_wr_ptr_q    <= {MAW{1'b0}};
      meta_rd_ptr_q    <= {MAW{1'b0}};
      meta_cnt_q       <= {(MAW+1){1'b0}};
      out_data_valid_q <= {NCH{1'b0}};
      out_data_q       <= 139'd0;
      out_meta_valid_q <= {NCH{1'b0}};
      out_meta_q       <= 360'd0;
      drop_cnt_q       <= 32'd0;
      buf_full_q       <= 1'b0;
    end else begin
      state_q          <= state_d;
      ch_q             <= ch_d;
      first_q          <= first_d;
      if (data_wr_s) data_wr_ptr_q <= data_wr_ptr_q + D_PTR_ONE_C;
      if (data_rd_s) data_rd_ptr_q <= data_rd_ptr_q + D_PTR_ONE_C;
      data_cnt_q       <= data_cnt_d;
      if (meta_wr_s) meta_wr_ptr_q <= meta_wr_ptr_q + M_PTR_ONE_C;
      if (meta_rd_s) meta_rd_ptr_q <= meta_rd_ptr_q + M_PTR_ONE_C;
      meta_cnt_q       <= meta_cnt_d;
      out_data_valid_q <= out_data_valid_d;
      out_data_q       <= out_data_d;
      out_meta_valid_q <= out_meta_valid_d;
      out_meta_q       <= out_meta_d;
      drop_cnt_q       <= drop_cnt_d;
      buf_full_q       <= buf_full_d;
    end
  end

  assign bus.out_data_valid = out_data_valid_q;
  assign bus.out_data       = out_data_q;
  assign bus.out_meta_valid = out_meta_valid_q;
  assign bus.out_meta       = out_meta_q;
  assign bus.buf_addr_full  = buf_full_q;
  assign drop_cnt           = drop_cnt_q;

endmodule

// File: tb/tb_parse_pkt_disp_nch.sv
// Directed and randomized bench for parse_pkt_disp_nch against a packet-level reference model.
module tb_parse_pkt_disp_nch;
  localparam int NCH = 4;
`ifdef DISP_DROP_ON_FULL_EN
  localparam bit DROP_ON_BUSY = 1'b1;
`else
  localparam bit DROP_ON_BUSY = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] drop_cnt;
  always #5 clk = ~clk;

  parse_pkt_disp_nch_if #(.NCH(NCH)) bus();

  parse_pkt_disp_nch #(
    .NCH(NCH), .CH_W(2), .DATA_DEPTH(256), .META_DEPTH(16), .FULL_MARGIN(64), .USEDW_TH(200)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus), .drop_cnt(drop_cnt)
  );

  typedef struct {
    logic [3:0]   dv;
    logic [138:0] d;
    logic [3:0]   mv;
    logic [359:0] m;
    int           cyc;
  } ev_t;

  ev_t          obs_q[$];
  ev_t          exp_q[$];
  logic [138:0] pw[$];
  logic [359:0] pm;
  int           cyc       = 0;
  int           pass_cnt  = 0;
  int           total_cnt = 0;
  int           exp_drops = 0;

  // Record every output strobe with its cycle stamp
  always @(negedge clk) begin
    ev_t e;
    cyc = cyc + 1;
    if ((bus.out_data_valid | bus.out_meta_valid) != 4'b0000) begin
      e.dv = bus.out_data_valid; e.d = bus.out_data;
      e.mv = bus.out_meta_valid; e.m = bus.out_meta; e.cyc = cyc;
      obs_q.push_back(e);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [359:0] obs, input logic [359:0] exp);
    total_cnt++;
    assert (obs === exp) begin
      pass_cnt++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] r128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Packet generator: head 101, mids 100 (optionally stray 101), tail 110; n==1 is a lone 110
  task automatic build_pkt(input logic [7:0] act, input int n, input bit mid_heads);
    logic [2:0] code;
    pw.delete();
    pm = {act, 16'($urandom()), r128(), r128(), 16'($urandom()), $urandom(), $urandom()};
    for (int i = 0; i < n; i++) begin
      if (i == n - 1)                                     code = 3'b110;
      else if (i == 0)                                    code = 3'b101;
      else if (mid_heads && ($urandom_range(0, 3) == 0))  code = 3'b101;
      else                                                code = 3'b100;
      pw.push_back({code, 4'($urandom_range(0, 15)), 4'b0000, r128()});
    end
  endtask

  // Reference: illegal/drop action (or busy when dropping on busy) counts a drop, else whole packet in order
  task automatic model_pkt(input bit busy);
    ev_t        e;
    logic [3:0] oh;
    int         chn;
    chn = int'(pm[358:352]);
    if (pm[359] || chn >= NCH || (busy && DROP_ON_BUSY)) begin
      exp_drops++;
    end else begin
      oh = 4'b0001 << chn;
      for (int i = 0; i < pw.size(); i++) begin
        e.dv = oh; e.d = pw[i]; e.mv = (i == 0) ? oh : 4'b0000; e.m = pm; e.cyc = 0;
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic drive_pkt(input bit with_meta, input bit gaps);
    for (int i = 0; i < pw.size(); i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          @(negedge clk);
          bus.pkt_valid = 1'b0; bus.pkt_metadata_valid = 1'b0;
        end
      end
      @(negedge clk);
      bus.pkt_valid          = 1'b1;
      bus.pkt_data           = pw[i];
      bus.pkt_metadata_valid = with_meta && (i == 0);
      bus.pkt_metadata       = pm;
    end
    @(negedge clk);
    bus.pkt_valid = 1'b0; bus.pkt_metadata_valid = 1'b0;
  endtask

  task automatic send_meta();
    @(negedge clk);
    bus.pkt_metadata_valid = 1'b1; bus.pkt_metadata = pm;
    @(negedge clk);
    bus.pkt_metadata_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (obs_q.size() < exp_q.size() && n < budget) begin
      @(negedge clk);
      n++;
    end
    repeat (6) @(negedge clk);
  endtask

  task automatic compare_stream(input string tag);
    int n;
    check({tag, "_count"}, 360'(obs_q.size()), 360'(exp_q.size()));
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_dv%0d", tag, i), 360'(obs_q[i].dv), 360'(exp_q[i].dv));
      check($sformatf("%s_d%0d", tag, i), 360'(obs_q[i].d), 360'(exp_q[i].d));
      check($sformatf("%s_mv%0d", tag, i), 360'(obs_q[i].mv), 360'(exp_q[i].mv));
      if (exp_q[i].mv != 4'b0000) check($sformatf("%s_m%0d", tag, i), obs_q[i].m, exp_q[i].m);
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int rel;
    reset                  = 1'b0;
    bus.pkt_valid          = 1'b0;
    bus.pkt_data           = 139'd0;
    bus.pkt_metadata_valid = 1'b0;
    bus.pkt_metadata       = 360'd0;
    bus.ch_usedw           = 32'd0;
    repeat (3) @(negedge clk);
    check("rst_dv", 360'(bus.out_data_valid), 360'(4'b0000));
    check("rst_mv", 360'(bus.out_meta_valid), 360'(4'b0000));
    check("rst_data", 360'(bus.out_data), 360'd0);
    check("rst_meta", bus.out_meta, 360'd0);
    check("rst_drop", 360'(drop_cnt), 360'd0);
    check("rst_full", 360'(bus.buf_addr_full), 360'd0);
    reset = 1'b1;

    // 3-word packet to channel 2, words on consecutive cycles
    build_pkt(8'h02, 3, 1'b0); model_pkt(1'b0); drive_pkt(1'b1, 1'b0);
    drain(40);
    if (obs_q.size() == 3) begin
      check("p3_back2back_a", 360'(obs_q[1].cyc - obs_q[0].cyc), 360'(1));
      check("p3_back2back_b", 360'(obs_q[2].cyc - obs_q[1].cyc), 360'(1));
    end
    compare_stream("p3");
    check("p3_drop", 360'(drop_cnt), 360'(exp_drops));

    // Drop actions: bit7 set, and channel index out of range
    build_pkt(8'h80, 2, 1'b0); model_pkt(1'b0); drive_pkt(1'b1, 1'b0);
    build_pkt(8'h05, 3, 1'b0); model_pkt(1'b0); drive_pkt(1'b1, 1'b0);
    drain(40);
    compare_stream("drops");
    check("drops_cnt", 360'(drop_cnt), 360'(exp_drops));

    // Busy channel 1 (usedw 201), release at exactly the threshold (200)
    bus.ch_usedw = 32'h0000_C900;
    build_pkt(8'h01, 3, 1'b0); model_pkt(1'b1); drive_pkt(1'b1, 1'b0);
    repeat (20) @(negedge clk);
    check("busy_hold", 360'(obs_q.size()), 360'd0);
    rel = cyc;
    bus.ch_usedw = 32'h0000_C800;
    drain(40);
    if (obs_q.size() > 0) check("busy_after_release", 360'(obs_q[0].cyc > rel), 360'd1);
    compare_stream("busy");
    check("busy_drop", 360'(drop_cnt), 360'(exp_drops));
    bus.ch_usedw = 32'd0;

    // Fill 193 words with no metadata yet, then let it drain to channel 1
    build_pkt(8'h01, 193, 1'b0); model_pkt(1'b0);
    for (int i = 0; i < 193; i++) begin
      @(negedge clk);
      bus.pkt_valid = 1'b1; bus.pkt_data = pw[i];
    end
    @(negedge clk);
    bus.pkt_valid = 1'b0;
    check("full_lag", 360'(bus.buf_addr_full), 360'd0);
    @(negedge clk);
    check("full_set", 360'(bus.buf_addr_full), 360'd1);
    send_meta();
    drain(400);
    check("full_clear", 360'(bus.buf_addr_full), 360'd0);
    compare_stream("fill");

    // One-word packets to channels 0,3,0: 2 idle cycles between strobes
    build_pkt(8'h00, 1, 1'b0); model_pkt(1'b0); drive_pkt(1'b1, 1'b0);
    build_pkt(8'h03, 1, 1'b0); model_pkt(1'b0); drive_pkt(1'b1, 1'b0);
    build_pkt(8'h00, 1, 1'b0); model_pkt(1'b0); drive_pkt(1'b1, 1'b0);
    drain(40);
    if (obs_q.size() == 3) begin
      check("gap_a", 360'(obs_q[1].cyc - obs_q[0].cyc), 360'(3));
      check("gap_b", 360'(obs_q[2].cyc - obs_q[1].cyc), 360'(3));
    end
    compare_stream("onew");

    // Reset in the middle of a 10-word send
    build_pkt(8'h02, 10, 1'b0);
    drive_pkt(1'b0, 1'b0);
    send_meta();
    for (int n = 0; n < 30 && obs_q.size() < 2; n++) @(negedge clk);
    check("mid_started", 360'(obs_q.size() >= 2), 360'd1);
    reset = 1'b0;
    @(negedge clk);
    check("mid_rst_dv", 360'(bus.out_data_valid), 360'(4'b0000));
    check("mid_rst_mv", 360'(bus.out_meta_valid), 360'(4'b0000));
    check("mid_rst_drop", 360'(drop_cnt), 360'd0);
    obs_q.delete(); exp_q.delete(); exp_drops = 0;
    reset = 1'b1;
    build_pkt(8'h03, 3, 1'b0); model_pkt(1'b0); drive_pkt(1'b1, 1'b0);
    drain(40);
    compare_stream("post_rst");

    // Randomized packets, lengths, gaps, stray head codes; usedw never above threshold
    for (int p = 0; p < 12; p++) begin
      logic [7:0] act;
      for (int k = 0; k < NCH; k++) bus.ch_usedw[8*k +: 8] = 8'($urandom_range(0, 200));
      if ($urandom_range(0, 3) != 0) act = 8'($urandom_range(0, 3));
      else                           act = 8'($urandom());
      build_pkt(act, $urandom_range(1, 6), 1'b1); model_pkt(1'b0); drive_pkt(1'b1, 1'b1);
    end
    drain(400);
    compare_stream("rand");
    check("rand_drop", 360'(drop_cnt), 360'(exp_drops));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
